// File: rtl/a2d_pkg.sv
// a2d_pkg: shared state encoding and command words for the A2D SPI interface.
`default_nettype none

package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TXN1 = 3'd1,
        GAP  = 3'd2,
        TXN2 = 3'd3,
        DONE = 3'd4
    } a2d_state_e;

    localparam logic [15:0] TXN2_CMD = 16'h0000;

    // First frame selects the channel; the ADC answers with the result in the second frame.
    function automatic logic [15:0] txn1_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mstr16.sv
// spi_mstr16: 16-bit SPI master frame engine (SCLK divider, shift register, bit counter).
`default_nettype none

module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt_i,
    input  logic [15:0] cmd_i,
    input  logic        ss_n_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        done_o,
    output logic [11:0] rx_o
);

    localparam int            CW       = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] CNT_RISE = CW'(SCLK_DIV / 2 - 1);

    logic          busy_q,  busy_d;
    logic [CW-1:0] div_q,   div_d;
    logic [3:0]    bit_q,   bit_d;
    logic [15:0]   shft_q,  shft_d;
    logic          smpl_q,  smpl_d;
    logic          sclk_q,  sclk_d;
    logic          done_q,  done_d;

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        bit_d  = bit_q;
        shft_d = shft_q;
        smpl_d = smpl_q;
        sclk_d = sclk_q;
        done_d = 1'b0;
        if (wrt_i) begin
            busy_d = 1'b1;
            div_d  = '0;
            bit_d  = 4'd0;
            shft_d = cmd_i;
            sclk_d = 1'b0;
        end else if (busy_q && !ss_n_i) begin
            div_d  = div_q + CW'(1);
            sclk_d = div_d[CW-1];
            if (div_q == CNT_RISE) begin
                smpl_d = miso_i;
            end
            // Counter wrap is the SCLK falling edge: commit the sampled bit.
            if (div_q == CNT_LAST) begin
                shft_d = {shft_q[14:0], smpl_q};
                if (bit_q == 4'd15) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    sclk_d = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= '0;
            bit_q  <= 4'd0;
            shft_q <= 16'h0000;
            smpl_q <= 1'b0;
            sclk_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            shft_q <= shft_d;
            smpl_q <= smpl_d;
            sclk_q <= sclk_d;
            done_q <= done_d;
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = shft_q[15];
    assign done_o = done_q;
    assign rx_o   = shft_q[11:0];

endmodule

`default_nettype wire

// File: rtl/a2d_intf.sv
// a2d_intf: two-frame SPI conversion sequencer for a 12-bit ADC.
// Build option: define A2D_RES_INV_EN to return the bitwise complement of the ADC result.
`default_nettype none

module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int            CW       = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] GAP_LAST = CW'(SCLK_DIV - 1);

    a2d_state_e    state_q, state_d;
    logic          ss_n_q,  ss_n_d;
    logic [CW-1:0] gap_q,   gap_d;
    logic          cmplt_q, cmplt_d;
    logic [11:0]   res_q,   res_d;

    logic          spi_wrt;
    logic [15:0]   spi_cmd;
    logic          spi_done;
    logic [11:0]   spi_rx;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cmplt_d = cmplt_q;
        res_d   = res_q;
        spi_wrt = 1'b0;
        spi_cmd = TXN2_CMD;
        unique case (state_q)
            IDLE: begin
                // The channel is captured straight into the SPI shift register here.
                if (strt_cnv) begin
                    state_d = TXN1;
                    spi_wrt = 1'b1;
                    spi_cmd = txn1_cmd(chnnl);
                    cmplt_d = 1'b0;
                end
            end
            TXN1: begin
                if (spi_done) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                gap_d = gap_q + CW'(1);
                if (gap_q == GAP_LAST) begin
                    state_d = TXN2;
                    spi_wrt = 1'b1;
                    spi_cmd = TXN2_CMD;
                end
            end
            TXN2: begin
                if (spi_done) begin
                    state_d = DONE;
                    cmplt_d = 1'b1;
`ifdef A2D_RES_INV_EN
                    res_d   = ~spi_rx;
`else
                    res_d   = spi_rx;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ss_n_d = !((state_d == TXN1) || (state_d == TXN2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ss_n_q  <= 1'b1;
            gap_q   <= '0;
            cmplt_q <= 1'b0;
            res_q   <= 12'h000;
        end else begin
            state_q <= state_d;
            ss_n_q  <= ss_n_d;
            gap_q   <= gap_d;
            cmplt_q <= cmplt_d;
            res_q   <= res_d;
        end
    end

    spi_mstr16 #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrt_i  (spi_wrt),
        .cmd_i  (spi_cmd),
        .ss_n_i (ss_n_q),
        .miso_i (MISO),
        .sclk_o (SCLK),
        .mosi_o (MOSI),
        .done_o (spi_done),
        .rx_o   (spi_rx)
    );

    assign SS_n      = ss_n_q;
    assign cnv_cmplt = cmplt_q;
    assign res       = res_q;

endmodule

`default_nettype wire
